// File: rtl/diffeq_seq_ctrl_if.sv
// Host-side bundle for the diffeq sequencer: run control, initial
// conditions in, solver state and status out.
interface diffeq_seq_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] aport;
    logic [WIDTH-1:0] dxport;
    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] u0;
    logic [WIDTH-1:0] xport;
    logic [WIDTH-1:0] yport;
    logic [WIDTH-1:0] uport;
    logic [CNT_W-1:0] iter_cnt;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output start, abort, aport, dxport, x0, y0, u0,
        input  xport, yport, uport, iter_cnt, busy, done, ovf
    );

    modport slave (
        input  start, abort, aport, dxport, x0, y0, u0,
        output xport, yport, uport, iter_cnt, busy, done, ovf
    );
endinterface

// File: rtl/diffeq_seq_ctrl.sv
// Multi-cycle diffeq solver sequencer: one shared multiplier walks the
// three products of each step before the state registers update.
module diffeq_seq_ctrl #(
    parameter int WIDTH    = 32,
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 1000
) (
    input  logic            clk,
    input  logic            reset,
    diffeq_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, CHECK, MUL1, MUL2, MUL3, UPDATE, DONE
    } state_t;

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_ITER);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_x, r_y, r_u, r_a, r_dx;
    logic [WIDTH-1:0] r_t1, r_t3, r_t5;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [WIDTH-1:0] w_ma, w_mb, w_prod;
    logic             w_lt;

    assign w_lt   = r_x < r_a;
    assign w_prod = w_ma * w_mb;

    // Operand select depends on state only; 5x and 3y use shift-add.
    always_comb begin
        w_ma = '0;
        w_mb = '0;
        unique case (r_state)
            MUL1: begin
                w_ma = r_u;
                w_mb = r_dx;
            end
            MUL2: begin
                w_ma = r_t1;
                w_mb = (r_x << 2) + r_x;
            end
            MUL3: begin
                w_ma = r_dx;
                w_mb = (r_y << 1) + r_y;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_next = CHECK;
            CHECK: begin
                if (bus.abort)                w_next = IDLE;
                else if (w_lt && r_cnt < LP_MAX) w_next = MUL1;
                else                          w_next = DONE;
            end
            MUL1:    w_next = bus.abort ? IDLE : MUL2;
            MUL2:    w_next = bus.abort ? IDLE : MUL3;
            MUL3:    w_next = bus.abort ? IDLE : UPDATE;
            UPDATE:  w_next = bus.abort ? IDLE : CHECK;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_u     <= '0;
            r_a     <= '0;
            r_dx    <= '0;
            r_t1    <= '0;
            r_t3    <= '0;
            r_t5    <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_x   <= bus.x0;
                        r_y   <= bus.y0;
                        r_u   <= bus.u0;
                        r_a   <= bus.aport;
                        r_dx  <= bus.dxport;
                        r_cnt <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                CHECK: begin
                    if (!bus.abort && w_lt && r_cnt >= LP_MAX)
                        r_ovf <= 1'b1;
                end
                MUL1: r_t1 <= w_prod;
                MUL2: r_t3 <= w_prod;
                MUL3: r_t5 <= w_prod;
                UPDATE: begin
                    if (!bus.abort) begin
                        r_x   <= r_x + r_dx;
                        r_y   <= r_y + r_t1;
                        r_u   <= r_u - r_t3 - r_t5;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.xport    = r_x;
    assign bus.yport    = r_y;
    assign bus.uport    = r_u;
    assign bus.iter_cnt = r_cnt;
    assign bus.ovf      = r_ovf;
    assign bus.busy     = r_state != IDLE;
    assign bus.done     = r_state == DONE;
endmodule
